// File: rtl/instr_encoder_loader_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader_pkg
// Shared definitions for the instruction encoder/loader and the control-unit
// decoder: op-class codes, instruction field positions, fixed class bit
// patterns, the NOP word, the descriptor struct handed to the field packer and
// the loader FSM state type.
// No ports (package).
// -----------------------------------------------------------------------------
package instr_encoder_loader_pkg;

   // Descriptor classes; codes 5-7 are illegal and never encoded
   typedef enum logic [2:0] {
      OP_DP_REG = 3'd0,
      OP_DP_IMM = 3'd1,
      OP_LDST   = 3'd2,
      OP_BRANCH = 3'd3,
      OP_NOP    = 3'd4
   } op_class_e;

   // Loader FSM states
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } load_state_e;

   // Field positions inside the 32-bit instruction word
   localparam int COND_LSB   = 28;
   localparam int COND_MSB   = 31;
   localparam int CLASS_LSB  = 25;
   localparam int CLASS_MSB  = 27;
   localparam int OPCODE_LSB = 21;
   localparam int OPCODE_MSB = 24;
   localparam int RN_LSB     = 16;
   localparam int RN_MSB     = 19;
   localparam int RD_LSB     = 12;
   localparam int RD_MSB     = 15;
   localparam int OP2_LSB    = 0;
   localparam int OP2_MSB    = 11;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   // Fixed upper class bits; DP and LD/ST append their I bit below these
   localparam logic [1:0] CLASS_DP     = 2'b00;
   localparam logic [1:0] CLASS_LDST   = 2'b01;
   localparam logic [2:0] CLASS_BRANCH = 3'b101;

   // Field-level op descriptor as presented on the loader input
   typedef struct packed {
      logic [2:0]  opClass;
      logic [3:0]  cond;
      logic [3:0]  opcode;
      logic        sBit;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [4:0]  shiftImm;
      logic [1:0]  shiftType;
      logic [11:0] imm12;
      logic        lsReg;
      logic        lsU;
      logic        lsB;
      logic        lsL;
      logic        brLink;
      logic [23:0] brOff;
   } op_desc_t;

   // Register-shifted operand shared by DP-reg and register-offset LD/ST
   function automatic logic [11:0] packShiftedReg(input logic [4:0] shiftImm,
                                                  input logic [1:0] shiftType,
                                                  input logic [3:0] rm);
      return {shiftImm, shiftType, 1'b0, rm};
   endfunction

endpackage

// File: rtl/instr_encoder_loader_field_pack.sv
// -----------------------------------------------------------------------------
// instr_field_pack
// Purely combinational packer: turns a field-level op descriptor into a 32-bit
// ARM-subset instruction word and flags whether the descriptor is legal.
// Optional build macro: ENC_CHECK_EN adds rejection of cond==4'b1111 and of
// DP-reg descriptors with rd==15 and S=1.
// Ports:
//   i_desc   in   op_desc_t  descriptor fields
//   o_word   out  32         encoded instruction (NOP_WORD for illegal classes)
//   o_legal  out  1          descriptor may be written to memory
// -----------------------------------------------------------------------------
module instr_field_pack
   import instr_encoder_loader_pkg::*;
(
   input  op_desc_t    i_desc,
   output logic [31:0] o_word,
   output logic        o_legal
);

   logic [11:0] w_shiftedReg;
   logic        w_checkFail;

   assign w_shiftedReg = packShiftedReg(i_desc.shiftImm, i_desc.shiftType, i_desc.rm);

   // Extra sanity checks: the "never" condition and a flag-setting write to PC
`ifdef ENC_CHECK_EN
   assign w_checkFail = (i_desc.cond == 4'hF) ||
                        ((i_desc.opClass == OP_DP_REG) && (i_desc.rd == 4'd15) && i_desc.sBit);
`else
   assign w_checkFail = 1'b0;
`endif

   // Build the word field by field from a zero base so unused bits stay 0
   always_comb begin
      o_word  = NOP_WORD;
      o_legal = 1'b1;
      case (i_desc.opClass)
         OP_DP_REG, OP_DP_IMM: begin
            o_word[COND_MSB:COND_LSB]     = i_desc.cond;
            o_word[CLASS_MSB:CLASS_LSB]   = {CLASS_DP, (i_desc.opClass == OP_DP_IMM)};
            o_word[OPCODE_MSB:OPCODE_LSB] = i_desc.opcode;
            o_word[20]                    = i_desc.sBit;
            o_word[RN_MSB:RN_LSB]         = i_desc.rn;
            o_word[RD_MSB:RD_LSB]         = i_desc.rd;
            o_word[OP2_MSB:OP2_LSB]       = (i_desc.opClass == OP_DP_IMM) ? i_desc.imm12 : w_shiftedReg;
         end
         OP_LDST: begin
            // P=1, W=0: pre-indexed without writeback is the only form supported
            o_word[COND_MSB:COND_LSB]   = i_desc.cond;
            o_word[CLASS_MSB:CLASS_LSB] = {CLASS_LDST, i_desc.lsReg};
            o_word[24]                  = 1'b1;
            o_word[23]                  = i_desc.lsU;
            o_word[22]                  = i_desc.lsB;
            o_word[21]                  = 1'b0;
            o_word[20]                  = i_desc.lsL;
            o_word[RN_MSB:RN_LSB]       = i_desc.rn;
            o_word[RD_MSB:RD_LSB]       = i_desc.rd;
            o_word[OP2_MSB:OP2_LSB]     = i_desc.lsReg ? w_shiftedReg : i_desc.imm12;
         end
         OP_BRANCH: begin
            o_word[COND_MSB:COND_LSB]   = i_desc.cond;
            o_word[CLASS_MSB:CLASS_LSB] = CLASS_BRANCH;
            o_word[24]                  = i_desc.brLink;
            o_word[23:0]                = i_desc.brOff;
         end
         OP_NOP: begin
            o_word = NOP_WORD;
         end
         default: begin
            o_legal = 1'b0;
         end
      endcase
      if (w_checkFail) begin
         o_legal = 1'b0;
      end
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
// Accepts field-level op descriptors on a valid/ready handshake, packs each
// into a 32-bit instruction word and writes it to instruction memory at an
// auto-incrementing word address through a req/ack write port. Used to load
// test programs before the pipeline runs.
// Optional build macro: ENC_CHECK_EN (extra legality checks in the packer).
// Parameters: ADDR_W word-address width, DEPTH words before full,
//             BASE_ADDR first address after reset/clear.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   clear                 restart loading at BASE_ADDR (deferred during a write)
//   op_valid / op_ready   descriptor handshake
//   op_class..br_off      descriptor fields
//   mem_req / mem_ack     write handshake, req held until ack
//   mem_addr / mem_wdata  write address and encoded word
//   count, full           words written since reset/clear, count==DEPTH
//   enc_err               one-cycle pulse when an illegal descriptor is dropped
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
   parameter int ADDR_W    = 8,
   parameter int DEPTH     = 256,
   parameter int BASE_ADDR = 0
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [2:0]        op_class,
   input  logic [3:0]        cond,
   input  logic [3:0]        opcode,
   input  logic              s_bit,
   input  logic [3:0]        rn,
   input  logic [3:0]        rd,
   input  logic [3:0]        rm,
   input  logic [4:0]        shift_imm,
   input  logic [1:0]        shift_type,
   input  logic [11:0]       imm12,
   input  logic              ls_reg,
   input  logic              ls_u,
   input  logic              ls_b,
   input  logic              ls_l,
   input  logic              br_link,
   input  logic [23:0]       br_off,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              enc_err
);

   import instr_encoder_loader_pkg::*;

   localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

   load_state_e       r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W:0]   r_count;
   logic [31:0]       r_word;
   logic              r_memReq;
   logic              r_encErr;
   logic              r_clrPend;

   op_desc_t          w_desc;
   logic [31:0]       w_word;
   logic              w_legal;
   logic              w_full;
   logic              w_canAccept;

   assign w_desc.opClass   = op_class;
   assign w_desc.cond      = cond;
   assign w_desc.opcode    = opcode;
   assign w_desc.sBit      = s_bit;
   assign w_desc.rn        = rn;
   assign w_desc.rd        = rd;
   assign w_desc.rm        = rm;
   assign w_desc.shiftImm  = shift_imm;
   assign w_desc.shiftType = shift_type;
   assign w_desc.imm12     = imm12;
   assign w_desc.lsReg     = ls_reg;
   assign w_desc.lsU       = ls_u;
   assign w_desc.lsB       = ls_b;
   assign w_desc.lsL       = ls_l;
   assign w_desc.brLink    = br_link;
   assign w_desc.brOff     = br_off;

   instr_field_pack u_pack (
      .i_desc  (w_desc),
      .o_word  (w_word),
      .o_legal (w_legal)
   );

   assign w_full      = (r_count == DEPTH_C);
   assign w_canAccept = (r_state == ST_IDLE) && !w_full;

   // Ready is gated by rst_n so it reads 0 while reset is held, and by clear so
   // no descriptor slips in on the cycle the address is being restarted.
   assign op_ready  = rst_n && w_canAccept && !clear;
   assign mem_req   = r_memReq;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_word;
   assign count     = r_count;
   assign full      = w_full;
   assign enc_err   = r_encErr;

   // Loader FSM: IDLE accepts and registers one encoded word, WRITE holds the
   // request stable until the memory acknowledges it. A clear seen during
   // WRITE is remembered and replaces the address/count increment on ack, so
   // the in-flight word still lands at its original address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_addr    <= BASE_A;
         r_count   <= '0;
         r_word    <= '0;
         r_memReq  <= 1'b0;
         r_encErr  <= 1'b0;
         r_clrPend <= 1'b0;
      end else begin
         r_encErr <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (clear) begin
                  r_addr  <= BASE_A;
                  r_count <= '0;
               end else if (op_valid && w_canAccept) begin
                  if (w_legal) begin
                     r_word   <= w_word;
                     r_memReq <= 1'b1;
                     r_state  <= ST_WRITE;
                  end else begin
                     r_encErr <= 1'b1;
                  end
               end
            end
            ST_WRITE: begin
               if (clear) begin
                  r_clrPend <= 1'b1;
               end
               if (mem_ack) begin
                  r_memReq  <= 1'b0;
                  r_clrPend <= 1'b0;
                  r_state   <= ST_IDLE;
                  if (r_clrPend || clear) begin
                     r_addr  <= BASE_A;
                     r_count <= '0;
                  end else begin
                     r_addr  <= r_addr + 1'b1;
                     r_count <= r_count + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
// Directed bench for instr_encoder_loader with a small transaction-level
// model (expected-word queue, write count) checked every falling edge, plus
// hand-computed literal words/addresses. Instance: ADDR_W=2, DEPTH=4,
// BASE_ADDR=0, so four writes both fill the memory and wrap the address.
// Honours ENC_CHECK_EN for the expected legality of cond=F / rd=15,S=1 ops.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

   localparam int ADDR_W    = 2;
   localparam int DEPTH     = 4;
   localparam int BASE_ADDR = 0;

   logic              clk;
   logic              rst_n;
   logic              clear;
   logic              op_valid;
   logic              op_ready;
   logic [2:0]        op_class;
   logic [3:0]        cond;
   logic [3:0]        opcode;
   logic              s_bit;
   logic [3:0]        rn;
   logic [3:0]        rd;
   logic [3:0]        rm;
   logic [4:0]        shift_imm;
   logic [1:0]        shift_type;
   logic [11:0]       imm12;
   logic              ls_reg;
   logic              ls_u;
   logic              ls_b;
   logic              ls_l;
   logic              br_link;
   logic [23:0]       br_off;
   logic              mem_req;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              enc_err;

   typedef struct {
      logic [2:0]  cls;
      logic [3:0]  cond;
      logic [3:0]  opcode;
      logic        s;
      logic [3:0]  rn;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [4:0]  shImm;
      logic [1:0]  shType;
      logic [11:0] imm12;
      logic        lsReg;
      logic        lsU;
      logic        lsB;
      logic        lsL;
      logic        brLink;
      logic [23:0] brOff;
   } tbDesc_t;

   int          nChecks = 0;
   int          nErrors = 0;

   // Model state: words accepted but not yet acknowledged, writes since clear
   logic [31:0] expQ[$];
   int          mCount    = 0;
   bit          mInWrite  = 1'b0;
   bit          mClrPend  = 1'b0;
   bit          mErr      = 1'b0;

   instr_encoder_loader #(
      .ADDR_W    (ADDR_W),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE_ADDR)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .op_class   (op_class),
      .cond       (cond),
      .opcode     (opcode),
      .s_bit      (s_bit),
      .rn         (rn),
      .rd         (rd),
      .rm         (rm),
      .shift_imm  (shift_imm),
      .shift_type (shift_type),
      .imm12      (imm12),
      .ls_reg     (ls_reg),
      .ls_u       (ls_u),
      .ls_b       (ls_b),
      .ls_l       (ls_l),
      .br_link    (br_link),
      .br_off     (br_off),
      .mem_req    (mem_req),
      .mem_ack    (mem_ack),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .count      (count),
      .full       (full),
      .enc_err    (enc_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Descriptor builders
   function automatic tbDesc_t newDesc(input logic [2:0] cls, input logic [3:0] c);
      tbDesc_t d;
      d = '{default: '0};
      d.cls  = cls;
      d.cond = c;
      return d;
   endfunction

   function automatic tbDesc_t dpReg(input logic [3:0] c, input logic [3:0] op, input logic s,
                                     input logic [3:0] n, input logic [3:0] dd, input logic [3:0] m);
      tbDesc_t d;
      d = newDesc(3'd0, c);
      d.opcode = op; d.s = s; d.rn = n; d.rd = dd; d.rm = m;
      return d;
   endfunction

   function automatic tbDesc_t dpImm(input logic [3:0] c, input logic [3:0] op,
                                     input logic [3:0] dd, input logic [11:0] imm);
      tbDesc_t d;
      d = newDesc(3'd1, c);
      d.opcode = op; d.rd = dd; d.imm12 = imm;
      return d;
   endfunction

   function automatic tbDesc_t ldst(input logic [3:0] c, input logic [3:0] n, input logic [3:0] dd,
                                    input logic [11:0] off, input logic u, input logic l);
      tbDesc_t d;
      d = newDesc(3'd2, c);
      d.rn = n; d.rd = dd; d.imm12 = off; d.lsU = u; d.lsL = l;
      return d;
   endfunction

   function automatic tbDesc_t branch(input logic [3:0] c, input logic link, input logic [23:0] off);
      tbDesc_t d;
      d = newDesc(3'd3, c);
      d.brLink = link; d.brOff = off;
      return d;
   endfunction

   // Reference encoding written as bit-position arithmetic
   function automatic logic [31:0] modelEncode(input tbDesc_t d);
      logic [31:0] w;
      logic [31:0] shifted;
      shifted = (32'(d.shImm) << 7) | (32'(d.shType) << 5) | 32'(d.rm);
      w = 32'(d.cond) << 28;
      case (d.cls)
         3'd0: w |= (32'(d.opcode) << 21) | (32'(d.s) << 20) | (32'(d.rn) << 16) |
                    (32'(d.rd) << 12) | shifted;
         3'd1: w |= (32'h1 << 25) | (32'(d.opcode) << 21) | (32'(d.s) << 20) |
                    (32'(d.rn) << 16) | (32'(d.rd) << 12) | 32'(d.imm12);
         3'd2: w |= (32'h1 << 26) | (32'(d.lsReg) << 25) | (32'h1 << 24) | (32'(d.lsU) << 23) |
                    (32'(d.lsB) << 22) | (32'(d.lsL) << 20) | (32'(d.rn) << 16) |
                    (32'(d.rd) << 12) | (d.lsReg ? shifted : 32'(d.imm12));
         3'd3: w |= (32'h5 << 25) | (32'(d.brLink) << 24) | 32'(d.brOff);
         default: w = 32'h0;
      endcase
      return w;
   endfunction

   function automatic bit modelLegal(input tbDesc_t d);
      if (d.cls > 3'd4) return 1'b0;
`ifdef ENC_CHECK_EN
      if (d.cond == 4'hF) return 1'b0;
      if ((d.cls == 3'd0) && (d.rd == 4'd15) && d.s) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic bit modelReady();
      return !mInWrite && (mCount != DEPTH) && !clear;
   endfunction

   function automatic logic [31:0] modelAddr();
      return 32'((BASE_ADDR + mCount) % (1 << ADDR_W));
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setInputs(input tbDesc_t d);
      op_class   = d.cls;
      cond       = d.cond;
      opcode     = d.opcode;
      s_bit      = d.s;
      rn         = d.rn;
      rd         = d.rd;
      rm         = d.rm;
      shift_imm  = d.shImm;
      shift_type = d.shType;
      imm12      = d.imm12;
      ls_reg     = d.lsReg;
      ls_u       = d.lsU;
      ls_b       = d.lsB;
      ls_l       = d.lsL;
      br_link    = d.brLink;
      br_off     = d.brOff;
   endtask

   // One clock; the model absorbs the handshake the bench drove into that edge
   task automatic tick();
      bit doAck;
      bit doClr;
      doAck = mem_ack && mInWrite;
      doClr = clear;
      @(posedge clk);
      #1;
      mErr = 1'b0;
      if (mInWrite) begin
         if (doClr) mClrPend = 1'b1;
         if (doAck) begin
            expQ.delete(0);
            mCount   = mClrPend ? 0 : mCount + 1;
            mClrPend = 1'b0;
            mInWrite = 1'b0;
         end
      end else if (doClr) begin
         mCount = 0;
      end
   endtask

   // Present a descriptor and return right after the edge that accepts it
   task automatic applyStimulus(input tbDesc_t d);
      int guard;
      setInputs(d);
      op_valid = 1'b1;
      guard = 0;
      while (!modelReady() && guard < 20) begin
         tick();
         guard++;
      end
      if (!modelReady()) begin
         nChecks++;
         nErrors++;
         $display("[TB] FAIL acceptTimeout: loader never became ready at %0t", $time);
         op_valid = 1'b0;
         return;
      end
      tick();
      op_valid = 1'b0;
      if (modelLegal(d)) begin
         expQ.push_back(modelEncode(d));
         mInWrite = 1'b1;
      end else begin
         mErr = 1'b1;
      end
   endtask

   task automatic finishWrite(input int delay);
      repeat (delay) tick();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   // Model comparison on every falling edge
   always @(negedge clk) begin
      if (!rst_n) begin
         checkOutput("rstReq", 32'(mem_req), 32'h0);
         checkOutput("rstReady", 32'(op_ready), 32'h0);
      end else begin
         checkOutput("cmpReady", 32'(op_ready), 32'(modelReady()));
         checkOutput("cmpReq", 32'(mem_req), 32'(mInWrite));
         checkOutput("cmpAddr", 32'(mem_addr), modelAddr());
         checkOutput("cmpCount", 32'(count), 32'(mCount));
         checkOutput("cmpFull", 32'(full), 32'(mCount == DEPTH));
         checkOutput("cmpErr", 32'(enc_err), 32'(mErr));
         if (mInWrite) begin
            if (expQ.size() == 0) begin
               nChecks++;
               nErrors++;
               $display("[TB] FAIL cmpQueue: write in flight with empty model queue at %0t", $time);
            end else begin
               checkOutput("cmpData", mem_wdata, expQ[0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      tbDesc_t d;
      rst_n    = 1'b0;
      clear    = 1'b0;
      op_valid = 1'b0;
      mem_ack  = 1'b0;
      setInputs(newDesc(3'd4, 4'h0));

      // Reset values
      #12;
      checkOutput("rstMemReq", 32'(mem_req), 32'h0);
      checkOutput("rstOpReady", 32'(op_ready), 32'h0);
      checkOutput("rstCount", 32'(count), 32'h0);
      checkOutput("rstFull", 32'(full), 32'h0);
      checkOutput("rstEncErr", 32'(enc_err), 32'h0);
      checkOutput("rstWdata", mem_wdata, 32'h0);
      checkOutput("rstAddr", 32'(mem_addr), 32'h0);
      #10;
      rst_n = 1'b1;
      tick();
      checkOutput("firstIdleReady", 32'(op_ready), 32'h1);

      // ADD r1,r2,r3 with same-cycle ack
      applyStimulus(dpReg(4'hE, 4'h4, 1'b0, 4'd2, 4'd1, 4'd3));
      checkOutput("addWord", mem_wdata, 32'hE082_1003);
      checkOutput("addAddr", 32'(mem_addr), 32'h0);
      finishWrite(0);
      checkOutput("addCount", 32'(count), 32'h1);

      // MOV r0,#5
      applyStimulus(dpImm(4'hE, 4'hD, 4'd0, 12'd5));
      checkOutput("movWord", mem_wdata, 32'hE3A0_0005);
      checkOutput("movAddr", 32'(mem_addr), 32'h1);
      finishWrite(1);

      // LDR r0,[r1,#4] with ack withheld for five cycles
      applyStimulus(ldst(4'hE, 4'd1, 4'd0, 12'd4, 1'b1, 1'b1));
      for (int i = 0; i < 5; i++) begin
         checkOutput("holdReq", 32'(mem_req), 32'h1);
         checkOutput("holdAddr", 32'(mem_addr), 32'h2);
         checkOutput("holdData", mem_wdata, 32'hE591_0004);
         checkOutput("holdReady", 32'(op_ready), 32'h0);
         tick();
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checkOutput("ldrCount", 32'(count), 32'h3);

      // Branch accepted on the very next edge after the ack
      applyStimulus(branch(4'hE, 1'b0, 24'h00_0010));
      checkOutput("brReq", 32'(mem_req), 32'h1);
      checkOutput("brWord", mem_wdata, 32'hEA00_0010);
      checkOutput("brAddr", 32'(mem_addr), 32'h3);
      finishWrite(0);

      // Full after four writes; address has wrapped
      checkOutput("fullFlag", 32'(full), 32'h1);
      checkOutput("fullReady", 32'(op_ready), 32'h0);
      checkOutput("fullCount", 32'(count), 32'h4);
      checkOutput("wrapAddr", 32'(mem_addr), 32'h0);

      // Descriptor held off while full, then released by clear
      d = newDesc(3'd4, 4'hE);
      setInputs(d);
      op_valid = 1'b1;
      repeat (3) tick();
      checkOutput("heldNoReq", 32'(mem_req), 32'h0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clearCount", 32'(count), 32'h0);
      applyStimulus(d);
      checkOutput("nopWord", mem_wdata, 32'h0);
      checkOutput("nopAddr", 32'(mem_addr), 32'h0);
      finishWrite(0);

      // Illegal class: pulse, no write
      applyStimulus(newDesc(3'd7, 4'hE));
      checkOutput("illegalErr", 32'(enc_err), 32'h1);
      checkOutput("illegalNoReq", 32'(mem_req), 32'h0);
      tick();
      checkOutput("illegalErrDone", 32'(enc_err), 32'h0);

      // cond=F and ADDS pc: rejected only with the extra checks enabled
      d = dpImm(4'hF, 4'hD, 4'd0, 12'd5);
      applyStimulus(d);
`ifdef ENC_CHECK_EN
      checkOutput("condFErr", 32'(enc_err), 32'h1);
      checkOutput("condFNoReq", 32'(mem_req), 32'h0);
      tick();
`else
      checkOutput("condFWord", mem_wdata, 32'hF3A0_0005);
      checkOutput("condFErr", 32'(enc_err), 32'h0);
      finishWrite(0);
`endif
      d = dpReg(4'hE, 4'h4, 1'b1, 4'd2, 4'd15, 4'd3);
      applyStimulus(d);
`ifdef ENC_CHECK_EN
      checkOutput("pcSErr", 32'(enc_err), 32'h1);
      tick();
`else
      checkOutput("pcSWord", mem_wdata, 32'hE092_F003);
      finishWrite(0);
`endif

      // clear during WRITE takes effect at the ack instead of the increment
      applyStimulus(dpReg(4'hE, 4'h4, 1'b0, 4'd2, 4'd1, 4'd3));
      clear = 1'b1;
      tick();
      clear = 1'b0;
      finishWrite(2);
      checkOutput("midClearCount", 32'(count), 32'h0);
      checkOutput("midClearAddr", 32'(mem_addr), 32'h0);
      applyStimulus(dpImm(4'hE, 4'hD, 4'd0, 12'd5));
      checkOutput("afterClearAddr", 32'(mem_addr), 32'h0);
      checkOutput("afterClearWord", mem_wdata, 32'hE3A0_0005);
      finishWrite(0);

      // Reset mid-WRITE drops the request immediately
      applyStimulus(branch(4'hE, 1'b1, 24'h00_0020));
      checkOutput("preRstReq", 32'(mem_req), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midRstReq", 32'(mem_req), 32'h0);
      checkOutput("midRstReady", 32'(op_ready), 32'h0);
      expQ.delete();
      mInWrite = 1'b0;
      mClrPend = 1'b0;
      mCount   = 0;
      mErr     = 1'b0;
      #10;
      rst_n = 1'b1;
      checkOutput("postRstCount", 32'(count), 32'h0);
      tick();
      applyStimulus(ldst(4'hE, 4'd1, 4'd0, 12'd4, 1'b1, 1'b1));
      checkOutput("postRstAddr", 32'(mem_addr), 32'h0);
      finishWrite(0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
